// File: rtl/npc_pkg.sv
// Constants and state encoding shared by the fetch unit and the decode stage.
package npc_pkg;

   localparam int unsigned     XLEN       = 32;
   localparam int unsigned     INST_WIDTH = 32;
   localparam logic [XLEN-1:0] RESET_PC   = 32'h8000_0000;

   typedef enum logic [2:0] {
      IFU_IDLE  = 3'd0,
      IFU_REQ   = 3'd1,
      IFU_RESP  = 3'd2,
      IFU_HOLD  = 3'd3,
      IFU_FAULT = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit boundary: instruction-memory request/response, decode handoff,
// execute redirect and the sticky fault flag.
interface ifu_fetch_if #(
   parameter int unsigned XLEN = npc_pkg::XLEN
);

   logic                            imem_req_valid;
   logic                            imem_req_ready;
   logic [XLEN-1:0]                 imem_req_addr;
   logic                            imem_rsp_valid;
   logic [npc_pkg::INST_WIDTH-1:0]  imem_rsp_data;
   logic                            imem_rsp_err;
   logic                            inst_valid;
   logic                            inst_ready;
   logic [npc_pkg::INST_WIDTH-1:0]  inst;
   logic [XLEN-1:0]                 inst_pc;
   logic                            redirect_valid;
   logic [XLEN-1:0]                 redirect_pc;
   logic                            fault;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ifu_pc_gen.sv
// Architectural PC register with next-PC selection (load > advance > hold)
// and the misaligned-target check on the load value.
module ifu_pc_gen #(
   parameter int unsigned     XLEN     = npc_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            advance_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_pc_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_next_o,
   output logic            misaligned_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (advance_i) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o         = pc_q;
   assign pc_next_o    = pc_d;
   assign misaligned_o = |load_pc_i[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, holds the word for decode,
// and kills in-flight fetches on execute redirects.
module ifu_fetch #(
   parameter int unsigned     XLEN     = npc_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   ifu_fetch_if.master bus
);

   import npc_pkg::*;

   ifu_state_e              state_q;
   logic                    kill_q;
   logic                    req_valid_q;
   logic [XLEN-1:0]         req_addr_q;
   logic                    inst_valid_q;
   logic [INST_WIDTH-1:0]   inst_q;
   logic [XLEN-1:0]         inst_pc_q;
   logic                    fault_q;

   logic [XLEN-1:0]         pc;
   logic [XLEN-1:0]         pc_next;
   logic                    misaligned;
   logic                    live;
   logic                    redir_ok;
   logic                    redir_bad;
   logic                    advance;

   always_comb begin
      live      = (state_q != IFU_FAULT);
      redir_ok  = bus.redirect_valid && !misaligned && live;
      redir_bad = bus.redirect_valid &&  misaligned && live;
      advance   = (state_q == IFU_HOLD) && bus.inst_ready && !bus.redirect_valid;
   end

   ifu_pc_gen #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .advance_i    (advance),
      .load_i       (redir_ok),
      .load_pc_i    (bus.redirect_pc),
      .pc_o         (pc),
      .pc_next_o    (pc_next),
      .misaligned_o (misaligned)
   );

   // Every path into (or staying in) REQ loads the request address from pc_next,
   // so a redirect or sequential advance is visible on the very next request cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IFU_IDLE;
         kill_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         fault_q      <= 1'b0;
      end else if (redir_bad) begin
         state_q      <= IFU_FAULT;
         kill_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b1;
      end else begin
         case (state_q)
            IFU_IDLE: begin
               state_q     <= IFU_REQ;
               req_valid_q <= 1'b1;
               req_addr_q  <= pc_next;
            end
            IFU_REQ: begin
               if (bus.imem_req_ready) begin
                  state_q     <= IFU_RESP;
                  req_valid_q <= 1'b0;
                  kill_q      <= redir_ok;
               end else begin
                  req_addr_q  <= pc_next;
               end
            end
            IFU_RESP: begin
               if (bus.imem_rsp_valid) begin
                  if (kill_q || redir_ok) begin
                     kill_q      <= 1'b0;
                     state_q     <= IFU_REQ;
                     req_valid_q <= 1'b1;
                     req_addr_q  <= pc_next;
                  end else if (bus.imem_rsp_err) begin
                     state_q <= IFU_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     inst_q       <= bus.imem_rsp_data;
                     inst_pc_q    <= pc;
                     inst_valid_q <= 1'b1;
                     state_q      <= IFU_HOLD;
                  end
               end else if (redir_ok) begin
                  kill_q <= 1'b1;
               end
            end
            IFU_HOLD: begin
               if (redir_ok || bus.inst_ready) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= IFU_REQ;
                  req_valid_q  <= 1'b1;
                  req_addr_q   <= pc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = req_addr_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.fault          = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory model, request/instruction scoreboard,
// and step-by-step checks of stalls, redirects, wrap and faults.
module tb_ifu_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic clk;
   logic rst_n;

   ifu_fetch_if #(.XLEN(32)) bus ();

   ifu_fetch #(
      .XLEN     (32),
      .RESET_PC (32'h8000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          pres_n = 0;
   int          hs_cyc0 = -1;
   int          pres_cyc[$];
   int          rsp_delay = 1;
   logic        err_arm = 1'b0;
   logic        iv_prev = 1'b0;
   logic [31:0] exp_req[$];
   exp_t        exp_inst[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_inst(input logic [31:0] pc);
      exp_inst.push_back('{pc: pc, word: mem_word(pc)});
   endtask

   task automatic check_reset();
      check("rst_req_valid",  bus.imem_req_valid, 0);
      check("rst_inst_valid", bus.inst_valid, 0);
      check("rst_fault",      bus.fault, 0);
      check("rst_inst",       bus.inst, 0);
      check("rst_inst_pc",    bus.inst_pc, 0);
      check("rst_req_addr",   bus.imem_req_addr, 32'h8000_0000);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_inst_valid(input string tag);
      int k = 0;
      while (!bus.inst_valid && k < 40) begin
         step();
         k++;
      end
      check(tag, bus.inst_valid, 1);
   endtask

   task automatic accept();
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   // Memory model: one response rsp_delay cycles after each accepted request.
   initial begin
      logic [31:0] a;
      logic        e;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            a = bus.imem_req_addr;
            e = err_arm;
            repeat (rsp_delay) @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(a);
            bus.imem_rsp_err   = e;
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
         end
      end
   end

   // Scoreboard: requests checked at handshake, instructions at presentation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (hs_cyc0 < 0) hs_cyc0 = cyc;
            check("req_expected", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) check("req_addr", bus.imem_req_addr, exp_req.pop_front());
         end
         if (bus.inst_valid && !iv_prev) begin
            exp_t x;
            pres_n++;
            pres_cyc.push_back(cyc);
            check("inst_expected", exp_inst.size() != 0, 1);
            if (exp_inst.size() != 0) begin
               x = exp_inst.pop_front();
               check("inst_pc", bus.inst_pc, x.pc);
               check("inst_word", bus.inst, x.word);
            end
         end
      end
      iv_prev = rst_n && bus.inst_valid;
   end

   initial begin
      int k;
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (3) step();
      check_reset();

      // Sequential fetch with an always-ready memory and decode.
      exp_req.push_back(32'h8000_0000);
      exp_req.push_back(32'h8000_0004);
      exp_req.push_back(32'h8000_0008);
      push_inst(32'h8000_0000);
      push_inst(32'h8000_0004);
      push_inst(32'h8000_0008);
      rst_n = 1'b1;
      k = 0;
      while (pres_n < 2 && k < 40) begin
         step();
         k++;
      end
      bus.inst_ready = 1'b0;
      check("seq_two_insts", pres_n, 2);
      if (pres_cyc.size() >= 2) begin
         check("lat_req_to_inst", pres_cyc[0] - hs_cyc0, 2);
         check("throughput", pres_cyc[1] - pres_cyc[0], 3);
      end

      // Decode back-pressure: word held, no new request.
      wait_inst_valid("hold_wait");
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", bus.inst_valid, 1);
         check("hold_inst", bus.inst, mem_word(32'h8000_0008));
         check("hold_pc", bus.inst_pc, 32'h8000_0008);
         check("hold_no_req", bus.imem_req_valid, 0);
         step();
      end

      // Redirect while the response is outstanding: stale word dropped.
      exp_req.push_back(32'h8000_000C);
      exp_req.push_back(32'h8000_0100);
      push_inst(32'h8000_0100);
      rsp_delay = 3;
      accept();
      step();
      redirect(32'h8000_0100);
      rsp_delay = 1;
      wait_inst_valid("kill_wait");
      check("kill_pc", bus.inst_pc, 32'h8000_0100);

      // Request stall, then redirect while unhandshaken.
      bus.imem_req_ready = 1'b0;
      accept();
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", bus.imem_req_valid, 1);
         check("stall_addr", bus.imem_req_addr, 32'h8000_0104);
         step();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0040;
      check("stall_redir_same_cycle", bus.imem_req_addr, 32'h8000_0104);
      step();
      bus.redirect_valid = 1'b0;
      check("stall_redir_valid", bus.imem_req_valid, 1);
      check("stall_redir_addr", bus.imem_req_addr, 32'h8000_0040);
      exp_req.push_back(32'h8000_0040);
      push_inst(32'h8000_0040);
      bus.imem_req_ready = 1'b1;
      wait_inst_valid("stall_wait");

      // Redirect in the same cycle as the request handshake.
      exp_req.push_back(32'h8000_0044);
      exp_req.push_back(32'h8000_0200);
      push_inst(32'h8000_0200);
      accept();
      redirect(32'h8000_0200);
      wait_inst_valid("hs_redir_wait");
      check("hs_redir_pc", bus.inst_pc, 32'h8000_0200);

      // Redirect in HOLD beats a simultaneous accept; then PC wraps to zero.
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0000_0000);
      push_inst(32'hFFFF_FFFC);
      push_inst(32'h0000_0000);
      bus.inst_ready = 1'b1;
      redirect(32'hFFFF_FFFC);
      bus.inst_ready = 1'b0;
      check("hold_redir_drop", bus.inst_valid, 0);
      check("hold_redir_req", bus.imem_req_valid, 1);
      wait_inst_valid("wrap_wait1");
      accept();
      check("wrap_addr", bus.imem_req_addr, 32'h0000_0000);
      wait_inst_valid("wrap_wait2");

      // Misaligned redirect target: sticky fault, later redirects ignored.
      redirect(32'h8000_0102);
      check("mis_fault", bus.fault, 1);
      check("mis_inst_valid", bus.inst_valid, 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0000;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mis_sticky", bus.fault, 1);
         check("mis_no_req", bus.imem_req_valid, 0);
      end
      bus.redirect_valid = 1'b0;

      // Asynchronous reset, then an access fault on the first response.
      rst_n = 1'b0;
      #1;
      check_reset();
      exp_req.push_back(32'h8000_0000);
      err_arm = 1'b1;
      step();
      rst_n = 1'b1;
      k = 0;
      while (!bus.imem_rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("err_rsp_seen", bus.imem_rsp_valid, 1);
      step();
      err_arm = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("err_fault", bus.fault, 1);
         check("err_no_req", bus.imem_req_valid, 0);
         check("err_no_inst", bus.inst_valid, 0);
         step();
      end

      check("req_queue_drained", exp_req.size(), 0);
      check("inst_queue_drained", exp_inst.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
